// File: rtl/hexdisp_pkg.sv
// hexdisp_pkg: shared state type and defaults for the hex display feeder
package hexdisp_pkg;
    typedef enum logic {IDLE, HOLD} hexdisp_state_t;
    localparam int NDIGITS_DEFAULT = 6;
endpackage

// File: rtl/hexdisp_if.sv
// hexdisp_if: valid/ready transfer of a packed multi-digit hex value
interface hexdisp_if
    import hexdisp_pkg::*;
#(
    parameter int NDIGITS = NDIGITS_DEFAULT
);
    logic                   data_valid;
    logic [4*NDIGITS-1:0]   data;
    logic                   data_ready;
    modport master (output data_valid, data, input data_ready);
    modport slave  (input data_valid, data, output data_ready);
endinterface

// File: rtl/hexdisp_blink_timer.sv
// blink_timer: free-running prescaler whose wrap toggles the blink phase
module blink_timer #(
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    output logic phase
);
    localparam int W = $clog2(BLINK_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(BLINK_CYCLES - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
endmodule

// File: rtl/hexdisp_ctrl.sv
// hexdisp_ctrl: rate-limited hex display feeder with leading-zero blanking and per-digit blink
module hexdisp_ctrl
    import hexdisp_pkg::*;
#(
    parameter int NDIGITS      = NDIGITS_DEFAULT,
    parameter int HOLD_CYCLES  = 5_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic                 clk,
    input  logic                 reset,
    hexdisp_if.slave             bus,
    input  logic                 blank_lz,
    input  logic [NDIGITS-1:0]   blink_en,
    output logic [4*NDIGITS-1:0] digit,
    output logic [NDIGITS-1:0]   digit_off,
    output logic                 update
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    hexdisp_state_t       state;
    logic [HW-1:0]        hold_cnt;
    logic                 loaded, loaded_nxt, accept, phase;
    logic [4*NDIGITS-1:0] digit_nxt;
    logic [NDIGITS-1:0]   off_nxt;

    // digit i is a leading zero when it and every digit above it are zero; digit 0 always shows
    function automatic logic [NDIGITS-1:0] lz_mask(input logic [4*NDIGITS-1:0] v);
        logic z;
        z = 1'b1;
        lz_mask = '0;
        for (int i = NDIGITS - 1; i > 0; i--) begin
            z = z && (v[4*i +: 4] == 4'h0);
            lz_mask[i] = z;
        end
    endfunction

    blink_timer #(.BLINK_CYCLES(BLINK_CYCLES)) u_blink (.clk(clk), .reset(reset), .phase(phase));

    always_comb begin
        accept     = bus.data_valid && bus.data_ready;
        digit_nxt  = accept ? bus.data : digit;
        loaded_nxt = loaded || accept;
        off_nxt    = ~{NDIGITS{loaded_nxt}} | (blank_lz ? lz_mask(digit_nxt) : '0)
                   | (blink_en & {NDIGITS{phase}});
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state          <= IDLE;
            hold_cnt       <= '0;
            bus.data_ready <= 1'b1;
            digit          <= '0;
            digit_off      <= '1;
            update         <= 1'b0;
            loaded         <= 1'b0;
        end else begin
            digit     <= digit_nxt;
            digit_off <= off_nxt;
            loaded    <= loaded_nxt;
            update    <= accept;
            if (state == IDLE) begin
                if (accept) begin
                    state          <= HOLD;
                    hold_cnt       <= HOLD_LOAD;
                    bus.data_ready <= 1'b0;
                end
            end else if (hold_cnt == '0) begin
                state          <= IDLE;
                bus.data_ready <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
endmodule

// File: tb/tb_hexdisp_ctrl.sv
// tb_hexdisp_ctrl: directed checks of transfer, hold-off, blanking, blink and reset
module tb_hexdisp_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        blank_lz = 1'b0;
    logic [5:0]  blink_en = '0;
    logic [23:0] digit;
    logic [5:0]  digit_off;
    logic        update;
    int          tests = 0;
    int          fails = 0;

    hexdisp_if #(.NDIGITS(6)) bus ();

    hexdisp_ctrl #(.NDIGITS(6), .HOLD_CYCLES(4), .BLINK_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .bus(bus), .blank_lz(blank_lz),
        .blink_en(blink_en), .digit(digit), .digit_off(digit_off), .update(update)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.data_valid = 1'b0;
        bus.data = '0;
        reset = 1'b1;
        repeat (3) tick();
        #2 reset = 1'b0;
        repeat (3) tick();
        tests++; if (digit_off !== 6'b111111) begin fails++; $display("FAIL reset_off got %b want 111111", digit_off); end
        tests++; if (digit !== 24'h0) begin fails++; $display("FAIL reset_digit got %h want 000000", digit); end
        tests++; if (bus.data_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.data_ready); end
        tests++; if (update !== 1'b0) begin fails++; $display("FAIL reset_update got %b want 0", update); end
    endtask

    task automatic test_load_blank();
        blank_lz = 1'b1;
        bus.data = 24'h00A05F;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        tests++; if (update !== 1'b1) begin fails++; $display("FAIL load_update got %b want 1", update); end
        tests++; if (digit !== 24'h00A05F) begin fails++; $display("FAIL load_digit got %h want 00a05f", digit); end
        tests++; if (digit_off !== 6'b110000) begin fails++; $display("FAIL load_off got %b want 110000", digit_off); end
        tests++; if (bus.data_ready !== 1'b0) begin fails++; $display("FAIL load_ready0 got %b want 0", bus.data_ready); end
        for (int i = 1; i < 4; i++) begin
            tick();
            tests++; if (bus.data_ready !== 1'b0 || update !== 1'b0) begin fails++; $display("FAIL hold_c%0d ready=%b update=%b want 0 0", i, bus.data_ready, update); end
        end
        tick();
        tests++; if (bus.data_ready !== 1'b1) begin fails++; $display("FAIL hold_end_ready got %b want 1", bus.data_ready); end
    endtask

    task automatic test_back_to_back();
        int ups;
        bus.data = 24'h0000C3;
        bus.data_valid = 1'b1;
        tick();
        bus.data = 24'h123456;
        ups = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ups += int'(update);
            tests++; if (digit !== 24'h0000C3) begin fails++; $display("FAIL b2b_held_c%0d got %h want 0000c3", i, digit); end
        end
        tick();
        ups += int'(update);
        tests++; if (bus.data_ready !== 1'b1 || digit !== 24'h0000C3) begin fails++; $display("FAIL b2b_ready_back ready=%b digit=%h want 1 0000c3", bus.data_ready, digit); end
        tick();
        ups += int'(update);
        bus.data_valid = 1'b0;
        tests++; if (digit !== 24'h123456 || update !== 1'b1) begin fails++; $display("FAIL b2b_accept digit=%h update=%b want 123456 1", digit, update); end
        tests++; if (digit_off !== 6'b000000) begin fails++; $display("FAIL b2b_off got %b want 000000", digit_off); end
        repeat (4) begin
            tick();
            ups += int'(update);
        end
        tests++; if (ups !== 1) begin fails++; $display("FAIL b2b_pulses got %0d want 1", ups); end
        tests++; if (bus.data_ready !== 1'b1) begin fails++; $display("FAIL b2b_final_ready got %b want 1", bus.data_ready); end
    endtask

    task automatic test_zero_value();
        bus.data = 24'h000000;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        tests++; if (digit_off !== 6'b111110) begin fails++; $display("FAIL zero_lz_off got %b want 111110", digit_off); end
        blank_lz = 1'b0;
        tick();
        tests++; if (digit_off !== 6'b000000) begin fails++; $display("FAIL zero_nolz_off got %b want 000000", digit_off); end
        for (int i = 0; i < 10 && bus.data_ready !== 1'b1; i++) tick();
        tests++; if (bus.data_ready !== 1'b1) begin fails++; $display("FAIL zero_ready_timeout got %b want 1", bus.data_ready); end
    endtask

    task automatic test_blink();
        logic prev;
        int   n;
        blink_en = 6'b000001;
        tick();
        prev = digit_off[0];
        n = 0;
        while (n < 20 && digit_off[0] === prev) begin
            tick();
            n++;
        end
        tests++; if (digit_off[0] === prev) begin fails++; $display("FAIL blink_first_toggle got %b want %b", digit_off[0], ~prev); end
        for (int r = 0; r < 3; r++) begin
            prev = digit_off[0];
            for (int c = 1; c < 8; c++) begin
                tick();
                tests++; if (digit_off !== {5'b0, prev}) begin fails++; $display("FAIL blink_hold_r%0d_c%0d got %b want %b", r, c, digit_off, {5'b0, prev}); end
            end
            tick();
            tests++; if (digit_off !== {5'b0, ~prev}) begin fails++; $display("FAIL blink_toggle_r%0d got %b want %b", r, digit_off, {5'b0, ~prev}); end
        end
        blink_en = '0;
        tick();
        tests++; if (digit_off !== 6'b000000) begin fails++; $display("FAIL blink_off got %b want 000000", digit_off); end
    endtask

    task automatic test_reset_in_hold();
        bus.data = 24'h0ABCDE;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        tests++; if (digit_off !== 6'b111111 || digit !== 24'h0) begin fails++; $display("FAIL rst_hold_dark off=%b digit=%h want 111111 000000", digit_off, digit); end
        tests++; if (bus.data_ready !== 1'b1 || update !== 1'b0) begin fails++; $display("FAIL rst_hold_ready ready=%b update=%b want 1 0", bus.data_ready, update); end
        #2 reset = 1'b0;
        repeat (3) begin
            tick();
            tests++; if (update !== 1'b0 || digit_off !== 6'b111111 || bus.data_ready !== 1'b1) begin fails++; $display("FAIL rst_hold_after update=%b off=%b ready=%b want 0 111111 1", update, digit_off, bus.data_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_load_blank();
        test_back_to_back();
        test_zero_value();
        test_blink();
        test_reset_in_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
